// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared widths and FSM encoding for the RAM-backed byte FIFO controller.
// Imported by the pointer tracker and the top-level controller.
package ram_fifo_ctrl_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;

   typedef enum logic {
      ST_IDLE       = 1'b0,
      ST_FETCH_WAIT = 1'b1
   } state_t;

   // Number of RAM entries for a given address width, sized to the count bus.
   function automatic logic [ADDR_W:0] depth_of(input int aw);
      return (ADDR_W+1)'(2 ** aw);
   endfunction

endpackage

// File: rtl/ram_fifo_ptr.sv
// Write/read pointer and occupancy tracker for the RAM half of the FIFO.
// Pointers wrap naturally; count covers 0..DEPTH inclusive.
module ram_fifo_ptr
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int AW = ADDR_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc_wr,
   input  logic          inc_rd,
   output logic [AW-1:0] wr_ptr,
   output logic [AW-1:0] rd_ptr,
   output logic [AW:0]   count,
   output logic          full
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(2 ** AW);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (inc_wr) wr_ptr <= wr_ptr + 1'b1;
         if (inc_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({inc_wr, inc_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign full = (count == DEPTH_C);

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Byte FIFO controller sequencing a single-port 16x8 RAM plus a one-entry
// output register; a fetch always wins the port over a write.
module ram_fifo_ctrl
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int DW = DATA_W,
   parameter int AW = ADDR_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          ram_rst,
   output logic          ram_wen,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   state_t        state;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          fetch;
   logic          wr_en;

   ram_fifo_ptr #(.AW(AW)) u_ptr (
      .clk    (clk),
      .reset  (reset),
      .inc_wr (wr_en),
      .inc_rd (fetch),
      .wr_ptr (wr_ptr),
      .rd_ptr (rd_ptr),
      .count  (count),
      .full   (full)
   );

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      fetch    = 1'b0;
      in_ready = 1'b0;
      wr_en    = 1'b0;
      ram_addr = wr_ptr;
      if (state == ST_IDLE && count != '0 && !out_valid) fetch = 1'b1;
      // Gating with reset makes ram_wen fall the instant reset asserts.
      in_ready = reset && !full && !fetch;
      wr_en    = in_valid && in_ready;
      if (fetch) ram_addr = rd_ptr;
   end

   assign ram_wen = wr_en;
   assign ram_din = in_data;
   assign ram_rst = ~reset;
   assign empty   = (count == '0) && !out_valid;

   // NOTE: the RAM array lives outside this block and is never cleared on
   // reset; only the pointers and count define which entries are live.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (out_valid && out_ready) out_valid <= 1'b0;
               if (fetch) state <= ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
               out_data  <= ram_dout;
               out_valid <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural 16x8 single-port
// RAM (one-cycle read latency) and a queue-based FIFO reference model.
module tb_ram_fifo_ctrl;
   import ram_fifo_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_data, out_data, ram_din, ram_dout;
   logic [4:0] count;
   logic       full, empty, ram_rst, ram_wen;
   logic [3:0] ram_addr;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ram_fifo_ctrl dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .full(full), .empty(empty),
      .ram_rst(ram_rst), .ram_wen(ram_wen), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   // Behavioural single-port RAM: read-first, registered output.
   logic [7:0] mem [16];
   always @(posedge clk) begin
      if (ram_rst) ram_dout <= 8'h00;
      else begin
         if (ram_wen) mem[ram_addr] <= ram_din;
         ram_dout <= mem[ram_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   // Offers a byte until accepted; returns just before the accepting edge.
   task automatic push_byte(input logic [7:0] b);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = b;
         #1;
         ok = in_ready;
      end
      if (!ok) check("push_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic       e_ir;
      logic       e_wen;
      logic       chk_addr;
      logic [3:0] e_addr;
      logic [4:0] e_cnt;
      logic       e_ov;
      logic [7:0] e_od;
      logic       e_empty;
   } vec_t;

   vec_t vecs [14];

   initial begin
      logic [7:0] q [$];
      logic [7:0] exp_b;
      int gap, nexp, pushed, popped, viol, nb, held;
      bit acc_prev;

      // Cycle-by-cycle table from reset: single byte, then a fetch/write collision.
      vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 5'd0, 1'b0, 8'h00, 1'b1};
      vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 5'd1, 1'b0, 8'h00, 1'b0};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 8'h00, 1'b1};
      vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 1'b1, 8'hA5, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 8'hA5, 1'b1};
      vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 5'd0, 1'b0, 8'hA5, 1'b1};
      vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 5'd1, 1'b0, 8'hA5, 1'b0};
      vecs[7]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 5'd0, 1'b0, 8'hA5, 1'b1};
      vecs[8]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 5'd1, 1'b1, 8'h11, 1'b0};
      vecs[9]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 4'd4, 5'd2, 1'b1, 8'h11, 1'b0};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd3, 1'b1, 8'h11, 1'b0};
      vecs[11] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 5'd3, 1'b0, 8'h11, 1'b0};
      vecs[12] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 5'd2, 1'b0, 8'h11, 1'b0};
      vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 5'd3, 1'b1, 8'h22, 1'b0};

      // Reset state, checked while reset is still asserted.
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
      #12;
      check("rst_outputs", {ram_rst, out_valid, out_data, ram_wen, count},
            {1'b1, 1'b0, 8'h00, 1'b0, 5'd0});
      do_reset();

      // Idle after reset: nothing moves for 20 cycles.
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         check($sformatf("idle_c%0d", c), {out_valid, empty, count, ram_wen, ram_rst},
               {1'b0, 1'b1, 5'd0, 1'b0, 1'b0});
      end

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
         #1;
         check($sformatf("v%0d.in_ready", i), in_ready, vecs[i].e_ir);
         check($sformatf("v%0d.ram_wen", i), ram_wen, vecs[i].e_wen);
         if (vecs[i].chk_addr) check($sformatf("v%0d.ram_addr", i), ram_addr, vecs[i].e_addr);
         if (vecs[i].e_wen) check($sformatf("v%0d.ram_din", i), ram_din, vecs[i].d);
         check($sformatf("v%0d.count", i), count, vecs[i].e_cnt);
         check($sformatf("v%0d.out_valid", i), out_valid, vecs[i].e_ov);
         check($sformatf("v%0d.out_data", i), out_data, vecs[i].e_od);
         check($sformatf("v%0d.empty", i), empty, vecs[i].e_empty);
      end

      // Fill: 16 bytes in RAM plus one in the output register.
      do_reset();
      for (int i = 0; i < 17; i++) push_byte(8'(i));
      @(negedge clk); in_data = 8'h11; #1;
      check("fill_state", {in_ready, full, count, out_valid, out_data},
            {1'b0, 1'b1, 5'd16, 1'b1, 8'h00});
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         check($sformatf("full_hold_c%0d", c), {in_ready, ram_wen, count}, {1'b0, 1'b0, 5'd16});
      end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      // Drain: in order, with exactly two empty cycles between bytes.
      gap = 0; nexp = 0;
      for (int c = 0; c < 200 && nexp < 17; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         if (out_valid) begin
            check($sformatf("drain_b%0d", nexp), out_data, 8'(nexp));
            if (nexp > 0) check($sformatf("drain_gap%0d", nexp), gap, 2);
            gap = 0; nexp++;
         end else gap++;
      end
      check("drain_total", nexp, 17);
      @(negedge clk); out_ready = 1'b0; #1;
      check("drain_empty", {empty, count}, {1'b1, 5'd0});

      // Randomized traffic against a queue model.
      do_reset();
      pushed = 0; popped = 0; viol = 0; nb = 0; acc_prev = 1'b0;
      for (int c = 0; c < 3000 && popped < 48; c++) begin
         @(negedge clk);
         if (acc_prev) in_valid = 1'b0;
         if (!in_valid && pushed < 48 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_data  = nb[7:0];
         end
         out_ready = ((c / 50) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
         #1;
         held = q.size() - int'(count) - int'(out_valid);
         if (held < 0 || held > 1) viol++;
         if (ram_wen && !(in_valid && in_ready)) viol++;
         if (ram_wen && ram_addr != 4'(pushed)) viol++;
         if (full !== (count == 5'd16)) viol++;
         acc_prev = in_valid && in_ready;
         if (acc_prev) begin
            q.push_back(in_data); pushed++; nb++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) viol++;
            else begin
               exp_b = q.pop_front();
               check($sformatf("rand_b%0d", popped), out_data, exp_b);
            end
            popped++;
         end
      end
      check("rand_popped", popped, 48);
      check("rand_violations", viol, 0);
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;

      // Reset during FETCH_WAIT with a write in progress.
      do_reset();
      for (int i = 0; i < 7; i++) push_byte(8'h70 + 8'(i));
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); in_valid = 1'b0; #1;
         if (out_valid && count == 5'd6) break;
      end
      check("pre_pop", {out_valid, count}, {1'b1, 5'd6});
      @(negedge clk); out_ready = 1'b1; #1;
      @(negedge clk); out_ready = 1'b0; #1;
      check("pre_fetch", {in_ready, out_valid, count}, {1'b0, 1'b0, 5'd6});
      @(negedge clk); in_valid = 1'b1; in_data = 8'h99; #1;
      check("fetch_wait_write", {ram_wen, count}, {1'b1, 5'd5});
      reset = 1'b0; #1;
      check("async_reset", {out_valid, count, ram_wen, in_ready, ram_rst},
            {1'b0, 5'd0, 1'b0, 1'b0, 1'b1});
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #1;
      check("post_reset_empty", {empty, out_valid, count}, {1'b1, 1'b0, 5'd0});
      push_byte(8'h3C);
      @(negedge clk); in_valid = 1'b0;
      for (int c = 0; c < 10 && !out_valid; c++) begin
         #1;
         if (!out_valid) @(negedge clk);
      end
      #1;
      check("post_reset_first", {out_valid, out_data}, {1'b1, 8'h3C});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
